cmd_demap: RTL and testbench

CMD_DEMAP -- requirements
Module: cmd_demap

---
 rtl/cmd_demap.sv | 230 +++++++++++++++++++++++
 tb/tb_cmd_demap.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_demap.sv
// cmd_demap: splits a host byte stream into packets and forwards each payload
// to the training-pattern FIFO or the sensor SPI command FIFO.
// Packet: SYNC, DEST, LEN, LEN payload bytes [, CHK].
// Optional feature macro: CMD_CHECKSUM_EN -- adds a trailing CHK byte that must
// equal the XOR of DEST, LEN and every payload byte.
module cmd_demap #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic       clk_fix,
  input  logic       rst_fix_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       train_wen,
  output logic [7:0] train_din,
  input  logic       train_full,
  output logic       sensor_wen,
  output logic [7:0] sensor_din,
  input  logic       sensor_full,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [7:0] err_cnt
);

  localparam logic [7:0]       DEST_TRAIN  = 8'h01;
  localparam logic [7:0]       DEST_SENSOR = 8'h02;
  localparam int               TMO_W       = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEST    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEST    = 2'd1,
    ST_LEN     = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;
`endif

  // Error counter never wraps: it sticks at its maximum.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic dest_is_valid(input logic [7:0] d);
    return (d == DEST_TRAIN) || (d == DEST_SENSOR);
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic             xfer;
  logic             sel_full;
  logic             sel_train;
  logic             drop;
  logic [7:0]       pay_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit_p0;
  logic             fwd_vld_p0;
  logic             end_vld_p0;
  logic             end_err_p0;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]       chk_acc;
`endif

  // Back-pressure only applies to a routed payload; dropped packets drain freely.
  assign sel_full = sel_train ? train_full : sensor_full;
  assign rx_ready = !((state == ST_PAYLOAD) && !drop && sel_full);
  assign xfer     = rx_valid & rx_ready;

  // The TIMEOUT-th consecutive idle cycle inside a packet aborts it.
  assign tmo_hit_p0 = (state != ST_IDLE) && !xfer && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: every advance needs a transfer; a timeout overrides everything.
  always_comb begin
    state_nxt = state;
    if (tmo_hit_p0) begin
      state_nxt = ST_IDLE;
    end else if (xfer) begin
      case (state)
        ST_IDLE:    if (rx_data == SYNC_BYTE) state_nxt = ST_DEST;
        ST_DEST:    state_nxt = ST_LEN;
        ST_LEN:     state_nxt = (rx_data == 8'd0) ? ST_IDLE : ST_PAYLOAD;
        ST_PAYLOAD: begin
          if (pay_cnt == 8'd1) begin
`ifdef CMD_CHECKSUM_EN
            state_nxt = ST_CHK;
`else
            state_nxt = ST_IDLE;
`endif
          end
        end
`ifdef CMD_CHECKSUM_EN
        ST_CHK:     state_nxt = ST_IDLE;
`endif
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode: payload forward strobe and packet-end classification.
  always_comb begin
    fwd_vld_p0 = 1'b0;
    end_vld_p0 = 1'b0;
    end_err_p0 = 1'b0;
    if (tmo_hit_p0) begin
      end_vld_p0 = 1'b1;
      end_err_p0 = 1'b1;
    end else if (xfer) begin
      case (state)
        ST_LEN: begin
          if (rx_data == 8'd0) begin
            end_vld_p0 = 1'b1;
            end_err_p0 = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          fwd_vld_p0 = !drop;
`ifndef CMD_CHECKSUM_EN
          if (pay_cnt == 8'd1) begin
            end_vld_p0 = 1'b1;
            end_err_p0 = drop;
          end
`endif
        end
`ifdef CMD_CHECKSUM_EN
        ST_CHK: begin
          end_vld_p0 = 1'b1;
          end_err_p0 = drop || (chk_acc != rx_data);
        end
`endif
        default: begin
          fwd_vld_p0 = 1'b0;
        end
      endcase
    end
  end

  // Per-packet context: route, drop flag, remaining payload bytes.
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      sel_train <= 1'b0;
      drop      <= 1'b0;
      pay_cnt   <= 8'd0;
    end else if (xfer && !tmo_hit_p0) begin
      case (state)
        ST_DEST: begin
          sel_train <= (rx_data == DEST_TRAIN);
          drop      <= !dest_is_valid(rx_data);
        end
        ST_LEN:     pay_cnt <= rx_data;
        ST_PAYLOAD: pay_cnt <= pay_cnt - 8'd1;
        default:    pay_cnt <= pay_cnt;
      endcase
    end
  end

`ifdef CMD_CHECKSUM_EN
  // Running XOR over DEST, LEN and payload; restarts with each DEST byte.
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      chk_acc <= 8'd0;
    end else if (xfer) begin
      case (state)
        ST_DEST:    chk_acc <= rx_data;
        ST_LEN:     chk_acc <= chk_acc ^ rx_data;
        ST_PAYLOAD: chk_acc <= chk_acc ^ rx_data;
        default:    chk_acc <= chk_acc;
      endcase
    end
  end
`endif

  // Idle-cycle counter: cleared in IDLE, on any transfer and when it fires.
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      tmo_cnt <= '0;
    end else if ((state == ST_IDLE) || xfer || tmo_hit_p0) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // ---- stage p0 -> p1: registered FIFO writes and packet status ----
  // FIFO write ports: the accepted byte appears one cycle after its transfer.
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      train_wen  <= 1'b0;
      train_din  <= 8'd0;
      sensor_wen <= 1'b0;
      sensor_din <= 8'd0;
    end else begin
      train_wen  <= fwd_vld_p0 && sel_train;
      sensor_wen <= fwd_vld_p0 && !sel_train;
      if (fwd_vld_p0 && sel_train)  train_din  <= rx_data;
      if (fwd_vld_p0 && !sel_train) sensor_din <= rx_data;
    end
  end

  // Packet status pulses and the saturating error count.
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      pkt_done <= end_vld_p0 && !end_err_p0;
      pkt_err  <= end_vld_p0 && end_err_p0;
      if (end_vld_p0 && end_err_p0) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_cmd_demap.sv
// tb_cmd_demap: table-driven and randomized checks of cmd_demap, in whichever
// build (CMD_CHECKSUM_EN defined or not) it is compiled with.
module tb_cmd_demap;

  localparam int TIMEOUT = 50000;

  logic       clk_fix = 1'b0;
  logic       rst_fix_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_ready;
  logic       train_wen, sensor_wen;
  logic [7:0] train_din, sensor_din;
  logic       train_full = 1'b0, sensor_full = 1'b0;
  logic       pkt_done, pkt_err;
  logic [7:0] err_cnt;

  always #5 clk_fix = ~clk_fix;

  cmd_demap #(.SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk_fix    (clk_fix),
    .rst_fix_n  (rst_fix_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .train_wen  (train_wen),
    .train_din  (train_din),
    .train_full (train_full),
    .sensor_wen (sensor_wen),
    .sensor_din (sensor_din),
    .sensor_full(sensor_full),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .err_cnt    (err_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Full flags: one driver, either random or manual.
  bit man_train_full = 0, man_sensor_full = 0, rand_full_en = 0;
  always @(posedge clk_fix) begin
    #2;
    train_full  = rand_full_en ? ($urandom_range(0, 9) < 3) : man_train_full;
    sensor_full = rand_full_en ? ($urandom_range(0, 9) < 3) : man_sensor_full;
  end

  // Monitor on the falling edge.
  logic [7:0] obs_train[$], obs_sensor[$];
  int n_done = 0, n_err = 0;
  bit overlap_seen = 0;
  always @(negedge clk_fix) begin
    if (train_wen)  obs_train.push_back(train_din);
    if (sensor_wen) obs_sensor.push_back(sensor_din);
    if (pkt_done) n_done++;
    if (pkt_err)  n_err++;
    if ((pkt_done && pkt_err) || (train_wen && sensor_wen)) overlap_seen = 1;
  end

  task automatic clear_obs();
    obs_train.delete();
    obs_sensor.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (1) begin
      @(negedge clk_fix);
      if (rx_ready) break;
      guard++;
      if (guard > 1000) begin
        check("rx_ready_wait_expired", 1, 0);
        break;
      end
    end
    @(posedge clk_fix);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk_fix);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_fix);
    rst_fix_n = 1'b0;
    @(negedge clk_fix);
    rst_fix_n = 1'b1;
    @(posedge clk_fix);
    #1;
  endtask

  // Model of the error counter.
  int exp_errcnt = 0;
  task automatic model_err();
    if (exp_errcnt < 255) exp_errcnt++;
  endtask

  typedef struct {
    int         n;
    logic [7:0] b[7];
    logic [7:0] chk;
    bit         send_chk;
    int         wdest;
    int         wn;
    logic [7:0] w[3];
    bit         good_nochk;
    bit         good_chk;
  } vec_t;

  vec_t vecs[7];

  // Compare observed writes and status against expectations for one packet.
  task automatic check_pkt(input string tag, input int wdest, input logic [7:0] expw[$],
                           input bit good);
    int ntr, nse;
    ntr = (wdest == 1) ? expw.size() : 0;
    nse = (wdest == 2) ? expw.size() : 0;
    check({tag, "_train_n"}, obs_train.size(), ntr);
    check({tag, "_sensor_n"}, obs_sensor.size(), nse);
    for (int i = 0; i < expw.size(); i++) begin
      if (wdest == 1 && i < obs_train.size())  check({tag, "_train_d"}, obs_train[i], expw[i]);
      if (wdest == 2 && i < obs_sensor.size()) check({tag, "_sensor_d"}, obs_sensor[i], expw[i]);
    end
    check({tag, "_done"}, n_done, good ? 1 : 0);
    check({tag, "_err"}, n_err, good ? 0 : 1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] expw[$];
    bit         good;
    int         cnt;

    // Reset state.
    repeat (2) @(negedge clk_fix);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_wen", {train_wen, sensor_wen}, 0);
    check("rst_din", {train_din, sensor_din}, 0);
    check("rst_pkt", {pkt_done, pkt_err}, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_fix_n = 1'b1;
    @(posedge clk_fix);
    #1;

    // Directed vector table.  XOR of DEST^LEN^payload is the CHK byte.
    vecs[0] = '{6, '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00}, 8'h02, 1, 1, 3,
                '{8'h11, 8'h22, 8'h33}, 1, 1};
    vecs[1] = '{5, '{8'hA5, 8'h02, 8'h02, 8'hA5, 8'h7E, 8'h00, 8'h00}, 8'hDB, 1, 2, 2,
                '{8'hA5, 8'h7E, 8'h00}, 1, 1};
    vecs[2] = '{4, '{8'hA5, 8'h05, 8'h01, 8'h44, 8'h00, 8'h00, 8'h00}, 8'h40, 1, 0, 0,
                '{8'h00, 8'h00, 8'h00}, 0, 0};
    vecs[3] = '{3, '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 0, 0, 0,
                '{8'h00, 8'h00, 8'h00}, 0, 0};
    vecs[4] = '{4, '{8'hA5, 8'h02, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00}, 8'hFF, 1, 2, 1,
                '{8'h5A, 8'h00, 8'h00}, 1, 0};
    vecs[5] = '{5, '{8'h33, 8'hA5, 8'h01, 8'h01, 8'hA5, 8'h00, 8'h00}, 8'hA5, 1, 1, 1,
                '{8'hA5, 8'h00, 8'h00}, 1, 1};
    vecs[6] = '{4, '{8'hA5, 8'hA5, 8'h01, 8'h77, 8'h00, 8'h00, 8'h00}, 8'hD3, 1, 0, 0,
                '{8'h00, 8'h00, 8'h00}, 0, 0};

    for (int v = 0; v < 7; v++) begin
      clear_obs();
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i]);
`ifdef CMD_CHECKSUM_EN
      if (vecs[v].send_chk) send_byte(vecs[v].chk);
      good = vecs[v].good_chk;
`else
      good = vecs[v].good_nochk;
`endif
      idle(3);
      expw.delete();
      for (int i = 0; i < vecs[v].wn; i++) expw.push_back(vecs[v].w[i]);
      check_pkt($sformatf("vec%0d", v), vecs[v].wdest, expw, good);
      if (!good) model_err();
    end
    check("vec_err_cnt", err_cnt, exp_errcnt);

    // Sensor FIFO full for 5 cycles mid-payload.
    clear_obs();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
    man_sensor_full = 1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    cnt = 0;
    repeat (5) begin
      @(negedge clk_fix);
      if (!rx_ready) cnt++;
    end
    @(posedge clk_fix);
    #1;
    man_sensor_full = 0;
    send_byte(8'hA5);
    send_byte(8'h7E);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'hDB);
`endif
    idle(3);
    check("stall_cycles", cnt, 5);
    expw = '{8'hA5, 8'h7E};
    check_pkt("stall", 2, expw, 1);

    // Reset mid-payload: outputs clear at once, stale bytes are ignored.
    clear_obs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03); send_byte(8'h11);
    #1;
    rst_fix_n = 1'b0;
    #1;
    check("arst_rx_ready", rx_ready, 1);
    check("arst_wen", {train_wen, sensor_wen}, 0);
    check("arst_din", {train_din, sensor_din}, 0);
    check("arst_err_cnt", err_cnt, 0);
    exp_errcnt = 0;
    @(negedge clk_fix);
    rst_fix_n = 1'b1;
    @(posedge clk_fix);
    #1;
    send_byte(8'h22); send_byte(8'h33);
    idle(3);
    expw.delete();
    clear_obs();
    check("arst_no_resume", obs_train.size() + n_done + n_err, 0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'hC3);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'hC0);
`endif
    idle(3);
    expw = '{8'hC3};
    check_pkt("post_rst", 2, expw, 1);

    // Timeout mid-payload, then a good packet.
    clear_obs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h55);
    cnt = 0;
    while (cnt < TIMEOUT + 100) begin
      @(negedge clk_fix);
      cnt++;
      if (pkt_err) break;
    end
    // Pulse is seen in the cycle after the TIMEOUT-th idle cycle.
    check("tmo_cycles", cnt, TIMEOUT + 1);
    idle(2);
    expw = '{8'h55};
    check_pkt("tmo", 1, expw, 0);
    model_err();
    clear_obs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h66);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h66);
`endif
    idle(3);
    expw = '{8'h66};
    check_pkt("after_tmo", 1, expw, 1);
    check("after_tmo_err_cnt", err_cnt, exp_errcnt);

    // err_cnt saturation over 300 bad packets.
    pulse_reset();
    exp_errcnt = 0;
    clear_obs();
    for (int p = 0; p < 300; p++) begin
`ifdef CMD_CHECKSUM_EN
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF);
`else
      send_byte(8'hA5); send_byte(8'h09); send_byte(8'h01); send_byte(8'h00);
`endif
      idle(1);
      model_err();
      if (p == 253) begin
        idle(1);
        check("sat_fe", err_cnt, 8'hFE);
      end
      if (p == 254) begin
        idle(1);
        check("sat_ff", err_cnt, 8'hFF);
      end
    end
    idle(2);
    check("sat_hold", err_cnt, 8'hFF);
    check("sat_err_pulses", n_err, 300);
    check("sat_done_pulses", n_done, 0);

    // Randomized packets against a behavioural model.
    pulse_reset();
    exp_errcnt = 0;
    rand_full_en = 1;
    for (int p = 0; p < 60; p++) begin
      logic [7:0] dest, len, x, chk;
      int         r, nj, wdest;
      clear_obs();
      q.delete();
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        x = 8'($urandom);
        if (x == 8'hA5) x = 8'h00;
        q.push_back(x);
      end
      r = $urandom_range(0, 3);
      dest = (r < 2) ? 8'h01 : (r == 2) ? 8'h02 : 8'($urandom_range(3, 255));
      len = 8'($urandom_range(0, 5));
      q.push_back(8'hA5); q.push_back(dest); q.push_back(len);
      chk = dest ^ len;
      expw.delete();
      for (int j = 0; j < len; j++) begin
        x = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
        q.push_back(x);
        expw.push_back(x);
        chk ^= x;
      end
      wdest = (dest == 8'h01) ? 1 : (dest == 8'h02) ? 2 : 0;
      good = (len != 0) && (wdest != 0);
`ifdef CMD_CHECKSUM_EN
      if (len != 0) begin
        if ($urandom_range(0, 4) == 0) begin
          chk ^= 8'h01;
          good = 0;
        end
        q.push_back(chk);
      end
`endif
      if (wdest == 0 || len == 0) expw.delete();
      foreach (q[i]) send_byte(q[i]);
      idle(3);
      check_pkt($sformatf("rnd%0d", p), wdest, expw, good);
      if (!good) model_err();
    end
    rand_full_en = 0;
    check("rnd_err_cnt", err_cnt, exp_errcnt);
    check("never_overlap", overlap_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
